serial_alu_seq: RTL and testbench

Bit-serial ALU sequencer that runs a full WIDTH-bit ALU operation through a single one-bit ALU slice, one bit per clock, least significant bit first. It sits directly around the one-bit slice. Upstream, it latches operands and the 4-bit ALU opcode, and each cycle it drives the slice's a/b/carry-in. Downstream, it consumes the slice's result and carry-out, shifting the result into a word register and keeping the carry in a flop between bits. It is the area-minimal alternative to a rippled 32-slice ALU.

---
 rtl/serial_alu_seq_if.sv | 25 ++
 rtl/serial_alu_seq.sv | 117 +++++++++++
 tb/tb_serial_alu_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_alu_seq_if.sv
// Operand/opcode request and result/flag bundle for serial_alu_seq.
interface serial_alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, alu_op,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, a, b, alu_op,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one WIDTH-bit op through a 1-bit slice, LSB first, one bit per clock.
// Optional SERIAL_ALU_SLT_EN turns opcode 0111 into set-less-than.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_alu_seq_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, result_q;
  logic [WIDTH-2:0] res_sh;
  logic [3:0]       op;
  logic             ci;
  logic [CW-1:0]    cnt;
  logic             cout_q, ovf_q;

  logic             last_bit, is_add, ma, mb, bit_s, cnxt, ovf_w;
  logic [WIDTH-1:0] res_full;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign is_add   = op[1];

  // One-bit slice; logic ops leave the carry flop untouched
  always_comb begin
    ma    = op[3] ? ~a_sh[0] : a_sh[0];
    mb    = op[2] ? ~b_sh[0] : b_sh[0];
    bit_s = 1'b0;
    cnxt  = ci;
    if (is_add) begin
      bit_s = ma ^ mb ^ ci;
      cnxt  = (ma & mb) | (ma & ci) | (mb & ci);
    end else begin
      bit_s = op[0] ? (ma | mb) : (ma & mb);
    end
  end

  // Final bit enters at the MSB, so on the last edge res_full is the aligned word
  assign res_full = {bit_s, res_sh};
  assign ovf_w    = ci ^ cnxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op       <= '0;
      ci       <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            op     <= bus.alu_op;
            ci     <= bus.alu_op[1] & bus.alu_op[2];
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_full[WIDTH-1:1];
          ci     <= cnxt;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            cnt <= '0;
`ifdef SERIAL_ALU_SLT_EN
            if (op == 4'b0111) begin
              result_q <= {{(WIDTH-1){1'b0}}, bit_s ^ ovf_w};
              cout_q   <= 1'b0;
              ovf_q    <= 1'b0;
            end else
`endif
            begin
              result_q <= res_full;
              cout_q   <= is_add & cnxt;
              ovf_q    <= is_add & ovf_w;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at WIDTH=8; SLT expectations follow SERIAL_ALU_SLT_EN.
module tb_serial_alu_seq;
  localparam int unsigned W = 8;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_NOR = 4'b1100, OP_SLT = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_alu_seq_if #(.WIDTH(W)) bus ();
  serial_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Drives start just after an edge; lat counts edges until done is seen (0 = timed out)
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] op,
                        output int lat, output int bcnt);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.alu_op = op;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL rst_result got=%h want=00", bus.result); end
    total++; if ({bus.carry_out, bus.overflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {bus.carry_out, bus.overflow}); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b want=1", bus.zero); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    int lat, bc;
    run_op(8'h7F, 8'h01, OP_ADD, lat, bc);
    total++; if (lat !== 9) begin bad++; $display("FAIL add_latency got=%0d want=9", lat); end
    total++; if (bc !== 8) begin bad++; $display("FAIL add_busy_cycles got=%0d want=8", bc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done got=%b want=0", bus.busy); end
    total++; if (bus.result !== 8'h80) begin bad++; $display("FAIL add_result got=%h want=80", bus.result); end
    total++; if ({bus.carry_out, bus.overflow, bus.zero} !== 3'b010) begin bad++; $display("FAIL add_flags c/v/z got=%b want=010", {bus.carry_out, bus.overflow, bus.zero}); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_width got=%b want=0", bus.done); end
    total++; if (bus.result !== 8'h80) begin bad++; $display("FAIL add_result_hold got=%h want=80", bus.result); end
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(8'h05, 8'h05, OP_SUB, lat, bc);
    total++; if (lat !== 9) begin bad++; $display("FAIL sub0_latency got=%0d want=9", lat); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL sub0_result got=%h want=00", bus.result); end
    total++; if ({bus.carry_out, bus.overflow, bus.zero} !== 3'b101) begin bad++; $display("FAIL sub0_flags c/v/z got=%b want=101", {bus.carry_out, bus.overflow, bus.zero}); end
    run_op(8'h00, 8'h01, OP_SUB, lat, bc);
    total++; if (bus.result !== 8'hFF) begin bad++; $display("FAIL sub1_result got=%h want=ff", bus.result); end
    total++; if ({bus.carry_out, bus.overflow, bus.zero} !== 3'b000) begin bad++; $display("FAIL sub1_flags c/v/z got=%b want=000", {bus.carry_out, bus.overflow, bus.zero}); end
  endtask

  task automatic test_logic();
    int lat, bc;
    run_op(8'hF0, 8'h0C, OP_AND, lat, bc);
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL and_result got=%h want=00", bus.result); end
    total++; if ({bus.carry_out, bus.overflow, bus.zero} !== 3'b001) begin bad++; $display("FAIL and_flags c/v/z got=%b want=001", {bus.carry_out, bus.overflow, bus.zero}); end
    run_op(8'hF0, 8'h0C, OP_OR, lat, bc);
    total++; if (bus.result !== 8'hFC) begin bad++; $display("FAIL or_result got=%h want=fc", bus.result); end
    total++; if ({bus.carry_out, bus.overflow, bus.zero} !== 3'b000) begin bad++; $display("FAIL or_flags c/v/z got=%b want=000", {bus.carry_out, bus.overflow, bus.zero}); end
    run_op(8'hF0, 8'h0C, OP_NOR, lat, bc);
    total++; if (bus.result !== 8'h03) begin bad++; $display("FAIL nor_result got=%h want=03", bus.result); end
    total++; if ({bus.carry_out, bus.overflow, bus.zero} !== 3'b000) begin bad++; $display("FAIL nor_flags c/v/z got=%b want=000", {bus.carry_out, bus.overflow, bus.zero}); end
  endtask

  task automatic test_start_during_busy();
    int lat;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h04; bus.alu_op = OP_ADD;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.alu_op = OP_OR; end
      if (bus.done) begin lat = i; break; end
    end
    bus.start = 1'b0;
    total++; if (lat !== 9) begin bad++; $display("FAIL busy_start_latency got=%0d want=9", lat); end
    total++; if (bus.result !== 8'h07) begin bad++; $display("FAIL busy_start_result got=%h want=07", bus.result); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_start_no_queue got=%b want=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [W-1:0] r1, r2;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.alu_op = OP_ADD;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin bus.a = 8'h40; bus.b = 8'h01; end
      if (bus.done) begin
        if (d1 == 0) begin d1 = i; r1 = bus.result; end
        else begin d2 = i; r2 = bus.result; bus.start = 1'b0; break; end
      end
    end
    bus.start = 1'b0;
    total++; if (d1 !== 9) begin bad++; $display("FAIL b2b_first_done got=%0d want=9", d1); end
    total++; if (d2 - d1 !== 10) begin bad++; $display("FAIL b2b_spacing got=%0d want=10", d2 - d1); end
    total++; if (r1 !== 8'h33) begin bad++; $display("FAIL b2b_result1 got=%h want=33", r1); end
    total++; if (r2 !== 8'h41) begin bad++; $display("FAIL b2b_result2 got=%h want=41", r2); end
    repeat (2) @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, dcount;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h0A; bus.alu_op = OP_ADD;
    repeat (4) begin @(posedge clk); #1; bus.start = 1'b0; end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", bus.busy); end
    rst_n = 1'b0; #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL rmid_result got=%h want=00", bus.result); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rmid_zero got=%b want=1", bus.zero); end
    dcount = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.done) dcount++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (bus.done) dcount++; end
    total++; if (dcount !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", dcount); end
    run_op(8'h03, 8'h04, OP_ADD, lat, bc);
    total++; if (lat !== 9) begin bad++; $display("FAIL rmid_fresh_latency got=%0d want=9", lat); end
    total++; if (bus.result !== 8'h07) begin bad++; $display("FAIL rmid_fresh_result got=%h want=07", bus.result); end
  endtask

  task automatic test_slt();
    int lat, bc;
    logic [W-1:0] exp1, exp2;
    logic c1, c2;
`ifdef SERIAL_ALU_SLT_EN
    exp1 = 8'h01; c1 = 1'b0; exp2 = 8'h00; c2 = 1'b0;
`else
    exp1 = 8'hFD; c1 = 1'b1; exp2 = 8'h03; c2 = 1'b0;
`endif
    run_op(8'hFE, 8'h01, OP_SLT, lat, bc);
    total++; if (bus.result !== exp1) begin bad++; $display("FAIL slt1_result got=%h want=%h", bus.result, exp1); end
    total++; if ({bus.carry_out, bus.overflow} !== {c1, 1'b0}) begin bad++; $display("FAIL slt1_flags c/v got=%b want=%b", {bus.carry_out, bus.overflow}, {c1, 1'b0}); end
    run_op(8'h01, 8'hFE, OP_SLT, lat, bc);
    total++; if (bus.result !== exp2) begin bad++; $display("FAIL slt2_result got=%h want=%h", bus.result, exp2); end
    total++; if ({bus.carry_out, bus.overflow} !== {c2, 1'b0}) begin bad++; $display("FAIL slt2_flags c/v got=%b want=%b", {bus.carry_out, bus.overflow}, {c2, 1'b0}); end
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_op = '0;
    test_reset();
    test_add_overflow();
    test_sub();
    test_logic();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_slt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
